// File: rtl/tail_light_sequencer.sv
// Two-bank PWM-dimmed tail-light sequencer: lamps ramp through LEVELS steps and sweep outward.
// Define TAIL_LIGHT_HAZARD_EN to compile in the hazard mode (left&right ramps both banks together).
`timescale 1ns/1ps
module tail_light_sequencer #(
  parameter int LAMPS       = 3,
  parameter int PWM_BITS    = 8,
  parameter int LEVELS      = 4,
  parameter int STEP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  output logic [2*LAMPS-1:0] light,
  output logic               active
);

  localparam int KW = $clog2(LEVELS + 1);
  localparam int IW = (LAMPS > 1) ? $clog2(LAMPS) : 1;
  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
`ifdef TAIL_LIGHT_HAZARD_EN
    , HAZARD
`endif
  } state_t;

  state_t               state, state_next;
  logic [IW-1:0]        lamp_idx, idx_next;
  logic [KW-1:0]        level, level_next;
  logic [TW-1:0]        tcnt, tcnt_next;
  logic [PWM_BITS-1:0]  pcnt;
  logic [2*LAMPS-1:0]   light_next;
  logic                 tick;
  int                   lvl;

  // Duty for level k is 2^(k*PWM_BITS/LEVELS)-1; the top level is the all-ones duty, i.e. always on.
  function automatic logic lamp_on(input int lv, input logic [PWM_BITS-1:0] cnt);
    logic [PWM_BITS:0] duty;
    duty = ((PWM_BITS+1)'(1) << (lv * PWM_BITS / LEVELS)) - (PWM_BITS+1)'(1);
    return (lv >= LEVELS) || ({1'b0, cnt} < duty);
  endfunction

  assign tick   = (tcnt == TW'(STEP_CYCLES - 1));
  assign active = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lamp_idx <= '0;
      level    <= '0;
      tcnt     <= '0;
      pcnt     <= '0;
      light    <= '0;
    end else begin
      state    <= state_next;
      lamp_idx <= idx_next;
      level    <= level_next;
      tcnt     <= tcnt_next;
      pcnt     <= pcnt + PWM_BITS'(1);
      light    <= light_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = lamp_idx;
    level_next = level;
    tcnt_next  = tcnt + TW'(1);
    case (state)
      IDLE: begin
        tcnt_next  = '0;
        idx_next   = '0;
        level_next = '0;
        if (left && !right) begin
          state_next = LEFT;
          level_next = KW'(1);
        end else if (right && !left) begin
          state_next = RIGHT;
          level_next = KW'(1);
        end
`ifdef TAIL_LIGHT_HAZARD_EN
        else if (left && right) begin
          state_next = HAZARD;
          level_next = KW'(1);
        end
`endif
      end
      LEFT, RIGHT: begin
        if (tick) begin
          tcnt_next = '0;
          if (level < KW'(LEVELS)) begin
            level_next = level + KW'(1);
          end else if (lamp_idx < IW'(LAMPS - 1)) begin
            idx_next   = lamp_idx + IW'(1);
            level_next = KW'(1);
          end else begin
            state_next = IDLE;
            idx_next   = '0;
            level_next = '0;
          end
        end
      end
`ifdef TAIL_LIGHT_HAZARD_EN
      HAZARD: begin
        if (tick) begin
          tcnt_next = '0;
          if (level < KW'(LEVELS)) begin
            level_next = level + KW'(1);
          end else begin
            state_next = IDLE;
            level_next = '0;
          end
        end
      end
`endif
      default: begin
        state_next = IDLE;
        tcnt_next  = '0;
        idx_next   = '0;
        level_next = '0;
      end
    endcase
  end

  // Lamps behind the sweep stay fully lit, the current lamp ramps, lamps ahead stay dark.
  always_comb begin
    light_next = '0;
    lvl        = 0;
    for (int j = 0; j < LAMPS; j++) begin
      if (j < int'(lamp_idx))       lvl = LEVELS;
      else if (j == int'(lamp_idx)) lvl = int'(level);
      else                          lvl = 0;
      if (state == RIGHT) light_next[j] = lamp_on(lvl, pcnt);
      if (state == LEFT)  light_next[2*LAMPS-1-j] = lamp_on(lvl, pcnt);
    end
`ifdef TAIL_LIGHT_HAZARD_EN
    if (state == HAZARD) light_next = {(2*LAMPS){lamp_on(int'(level), pcnt)}};
`endif
  end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Self-checking bench for tail_light_sequencer: randomized requests checked against an
// elapsed-time lamp model (step = cycles/STEP, lamp = step/LEVELS, level = step%LEVELS+1).
`timescale 1ns/1ps
module tb_tail_light_sequencer;
  localparam int LAMPS    = 3;
  localparam int PWM_BITS = 8;
  localparam int LEVELS   = 4;
  localparam int STEP     = 16;
  localparam int SEQ_LEN  = LAMPS * LEVELS * STEP;
  localparam int HAZ_LEN  = LEVELS * STEP;
  localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic left = 1'b0;
  logic right = 1'b0;
  logic [2*LAMPS-1:0] light;
  logic active;

  int n_cmp = 0;
  int n_bad = 0;
  int m_mode = M_IDLE;
  int m_n = 0;
  int m_pcnt = 0;
  logic [2*LAMPS-1:0] exp_light = '0;
  logic exp_active = 1'b0;

  tail_light_sequencer #(
    .LAMPS(LAMPS), .PWM_BITS(PWM_BITS), .LEVELS(LEVELS), .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .light(light), .active(active)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic lamp_on(input int lv, input int p);
    int duty;
    duty = (1 << (lv * PWM_BITS / LEVELS)) - 1;
    return (duty == (1 << PWM_BITS) - 1) || (p < duty);
  endfunction

  function automatic logic [2*LAMPS-1:0] lights_for(input int mode, input int n, input int p);
    logic [2*LAMPS-1:0] v;
    int stp, lamp, k, lv;
    v = '0;
    if (mode == M_LEFT || mode == M_RIGHT) begin
      stp  = n / STEP;
      lamp = stp / LEVELS;
      k    = stp % LEVELS + 1;
      for (int j = 0; j < LAMPS; j++) begin
        lv = (j < lamp) ? LEVELS : ((j == lamp) ? k : 0);
        if (mode == M_RIGHT) v[j] = lamp_on(lv, p);
        else v[2*LAMPS-1-j] = lamp_on(lv, p);
      end
    end else if (mode == M_HAZ) begin
      k = n / STEP + 1;
      for (int j = 0; j < 2*LAMPS; j++) v[j] = lamp_on(k, p);
    end
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_n = 0;
    m_pcnt = 0;
    exp_light = '0;
    exp_active = 1'b0;
  endtask

  task automatic model_edge(input logic l, input logic r);
    if (reset == 1'b0) begin
      model_reset();
    end else begin
      exp_light = lights_for(m_mode, m_n, m_pcnt);
      m_pcnt = (m_pcnt + 1) % (1 << PWM_BITS);
      if (m_mode == M_IDLE) begin
        m_n = 0;
        if (l && !r) m_mode = M_LEFT;
        else if (r && !l) m_mode = M_RIGHT;
`ifdef TAIL_LIGHT_HAZARD_EN
        else if (l && r) m_mode = M_HAZ;
`endif
      end else begin
        m_n++;
        if (m_n == ((m_mode == M_HAZ) ? HAZ_LEN : SEQ_LEN)) begin
          m_mode = M_IDLE;
          m_n = 0;
        end
      end
      exp_active = (m_mode != M_IDLE);
    end
  endtask

  task automatic cyc(input logic l, input logic r);
    left = l;
    right = r;
    @(posedge clk);
    model_edge(l, r);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 1'b0);
      n_cmp++;
      if (light !== '0 || active !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL reset_hold: light=%b active=%b, required 0/0", light, active);
      end
    end
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    n_cmp++;
    if (active !== 1'b1 || light !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_release: light=%b active=%b, required 0/1", light, active);
    end
    for (int c = 0; c < SEQ_LEN + 20; c++) begin
      cyc(1'b0, 1'b0);
      n_cmp++;
      if (light !== exp_light || active !== exp_active) begin
        n_bad++;
        $display("[TB] FAIL reset_left_seq @%0t: light=%b active=%b, required %b/%b",
                 $time, light, active, exp_light, exp_active);
      end
      if (!exp_active && c > SEQ_LEN) break;
    end
  endtask

  task automatic test_right_seq();
    int act_cycles;
    cyc(1'b0, 1'b1);
    act_cycles = active ? 1 : 0;
    for (int c = 0; c < SEQ_LEN + 10; c++) begin
      cyc(1'b0, 1'b0);
      if (active) act_cycles++;
      n_cmp++;
      if (light !== exp_light || active !== exp_active || light[5:3] !== 3'b000) begin
        n_bad++;
        $display("[TB] FAIL right_seq @%0t: light=%b active=%b, required %b/%b",
                 $time, light, active, exp_light, exp_active);
      end
    end
    n_cmp++;
    if (act_cycles != SEQ_LEN) begin
      n_bad++;
      $display("[TB] FAIL right_seq_length: active for %0d cycles, required %0d", act_cycles, SEQ_LEN);
    end
  endtask

  task automatic test_left_glitch();
    int g;
    g = int'($urandom_range(20, 150));
    cyc(1'b1, 1'b0);
    for (int c = 1; c < SEQ_LEN + 10; c++) begin
      cyc(1'b0, c == g);
      n_cmp++;
      if (light !== exp_light || active !== exp_active || light[2:0] !== 3'b000) begin
        n_bad++;
        $display("[TB] FAIL left_glitch @%0t: light=%b active=%b, required %b/%b",
                 $time, light, active, exp_light, exp_active);
      end
    end
  endtask

  task automatic test_held_request();
    int rises, gaps;
    logic prev;
    rises = 0;
    gaps = 0;
    prev = active;
    for (int c = 0; c < 500; c++) begin
      cyc(1'b0, 1'b1);
      if (active && !prev) rises++;
      if (!active && rises > 0) gaps++;
      prev = active;
      n_cmp++;
      if (light !== exp_light || active !== exp_active) begin
        n_bad++;
        $display("[TB] FAIL held_request @%0t: light=%b active=%b, required %b/%b",
                 $time, light, active, exp_light, exp_active);
      end
    end
    n_cmp++;
    if (rises != 3 || gaps != 2) begin
      n_bad++;
      $display("[TB] FAIL held_request_count: starts=%0d gaps=%0d, required 3/2", rises, gaps);
    end
    for (int c = 0; c < SEQ_LEN + 10; c++) begin
      cyc(1'b0, 1'b0);
      n_cmp++;
      if (light !== exp_light || active !== exp_active) begin
        n_bad++;
        $display("[TB] FAIL held_drain @%0t: light=%b active=%b, required %b/%b",
                 $time, light, active, exp_light, exp_active);
      end
    end
  endtask

  task automatic test_hazard();
`ifdef TAIL_LIGHT_HAZARD_EN
    int act_cycles;
    cyc(1'b1, 1'b1);
    act_cycles = active ? 1 : 0;
    for (int c = 0; c < HAZ_LEN + 10; c++) begin
      cyc(1'b0, 1'b0);
      if (active) act_cycles++;
      n_cmp++;
      if (light !== exp_light || active !== exp_active) begin
        n_bad++;
        $display("[TB] FAIL hazard_on @%0t: light=%b active=%b, required %b/%b",
                 $time, light, active, exp_light, exp_active);
      end
    end
    n_cmp++;
    if (act_cycles != HAZ_LEN) begin
      n_bad++;
      $display("[TB] FAIL hazard_length: active for %0d cycles, required %0d", act_cycles, HAZ_LEN);
    end
`else
    for (int c = 0; c < 100; c++) begin
      cyc(1'b1, 1'b1);
      n_cmp++;
      if (light !== '0 || active !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL hazard_off @%0t: light=%b active=%b, required 0/0", $time, light, active);
      end
    end
    cyc(1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 1'b1);
    for (int c = 1; c < 100; c++) begin
      cyc(1'b0, 1'b0);
      n_cmp++;
      if (light !== exp_light || active !== exp_active) begin
        n_bad++;
        $display("[TB] FAIL reset_mid_pre @%0t: light=%b active=%b, required %b/%b",
                 $time, light, active, exp_light, exp_active);
      end
    end
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (light !== '0 || active !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_async: light=%b active=%b, required 0/0", light, active);
    end
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    for (int c = 0; c < SEQ_LEN + 10; c++) begin
      cyc(1'b0, 1'b0);
      n_cmp++;
      if (light !== exp_light || active !== exp_active) begin
        n_bad++;
        $display("[TB] FAIL reset_mid_restart @%0t: light=%b active=%b, required %b/%b",
                 $time, light, active, exp_light, exp_active);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 15));
      cyc(r == 0 || r == 2, r == 1 || r == 2);
      n_cmp++;
      if (light !== exp_light || active !== exp_active) begin
        n_bad++;
        $display("[TB] FAIL random @%0t: light=%b active=%b, required %b/%b",
                 $time, light, active, exp_light, exp_active);
      end
    end
  endtask

  initial begin
    test_reset();
    test_right_seq();
    test_left_glitch();
    test_held_request();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tail_light_sequencer.md
# tail_light_sequencer

Parametrised successor to the team's dimmed Thunderbird-style tail-light controller. It drives two banks of LAMPS lamps, left and right. Each lamp is a PWM output that ramps through LEVELS brightness steps, and lamps light one after another outward along the active bank. Optionally, a hazard mode ramps both banks together. The block sits between the debounced turn-signal switches and the board LED pins.

## Interface
- LAMPS, 3: lamps per bank; ≥1.
- PWM_BITS, 8: PWM counter/duty width; must be a multiple of LEVELS.
- LEVELS, 4: brightness steps per lamp; ≥1.
- STEP_CYCLES, 16: clock cycles each brightness step is held; ≥1.
- clk  input  1  single system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately.
- left  input  1  left turn request, synchronous to clk.
- right  input  1  right turn request, synchronous to clk.
- light  output  2*LAMPS  lamp drive. Right lamp j maps to light[j]. Left lamp j maps to light[2*LAMPS-1-j].
- active  output  1  high while a sequence runs (state ≠ IDLE).

## Operation
- PWM: free-running PWM_BITS counter `pcnt`, increments every cycle and wraps to 0.
- Duty for level k (0..LEVELS) is (1 << (k*PWM_BITS/LEVELS)) − 1. With defaults: 0, 3, 15, 63, 255.
- A lamp is on when duty == all-ones, or when `pcnt` < duty. Level LEVELS is therefore constantly on, and level 0 is constantly off.
- Step timer: counter 0..STEP_CYCLES−1, held at 0 in IDLE. A step tick fires when it reaches STEP_CYCLES−1, after which it wraps to 0.
- FSM states and transitions:
  - IDLE: all duties 0.
    - left&~right → LEFT.
    - right&~left → RIGHT.
    - left&right → HAZARD (macro on) or stay IDLE (macro off).
    - Neither → stay IDLE.
  - LEFT/RIGHT: lamp index i=0, level k=1 on entry.
    - Each tick: if k<LEVELS then k++. Otherwise, if i<LAMPS−1 then i++ and k=1.
    - At i=LAMPS−1, k=LEVELS, the next tick → IDLE.
    - Lamps below i hold level LEVELS, lamp i holds level k, and lamps above i are at 0. The other bank is 0.
  - HAZARD: all 2*LAMPS lamps share level k, starting at k=1, with k++ each tick. At k=LEVELS, the next tick → IDLE.
- Direction is latched at sequence start. Changes to left/right mid-sequence are ignored.
- IDLE is always occupied for at least one cycle between sequences, with all lamps dark. Holding a request therefore restarts the sequence with a one-cycle dark gap.

## Timing
- Reset values: light=0, active=0, pcnt=0, step timer=0, state=IDLE, i=0, k=0.
- Reset asserted mid-sequence: outputs clear asynchronously. The first sequence after release starts from a sampled request.
- light is registered: light at cycle t+1 = PWM compare of `pcnt` and duty at cycle t.
- Request sampled in IDLE at edge t:
  - active=1 from t+1.
  - The first lamp shows level 1 from t+2.
- Step duration: each (i,k) pair is held exactly STEP_CYCLES cycles.
- LEFT/RIGHT sequence length: LAMPS*LEVELS*STEP_CYCLES cycles. HAZARD length: LEVELS*STEP_CYCLES cycles.
- After the final step, active=0 for ≥1 cycle and light=0 one cycle after that.
- STEP_CYCLES=1 is legal: the state advances every cycle.

## Configuration
- TAIL_LIGHT_HAZARD_EN defined: left&right in IDLE enters HAZARD as described.
- Undefined: the HAZARD state is not compiled in. left&right is treated as no request and the block stays in IDLE with light=0 and active=0.

## Test plan
All scenarios use defaults: LAMPS=3, PWM_BITS=8, LEVELS=4, STEP_CYCLES=16.
- Reset: hold reset=0 with left=1 → light=0 and active=0. Then release reset → the left sequence starts: active=1 one cycle after the first sampled edge.
- Right sequence: pulse right=1 for 1 cycle.
  - During the first step, light[0] is high exactly 3 of every 256 cycles.
  - During step 4, light[0] is high constantly.
  - Across the whole sequence, light[5:3] is always 0.
  - active falls 192 cycles after it rose.
- Left sequence with a right glitch mid-run: assert left, then pulse right at cycle 50.
  - The glitch has no effect: light[5] reaches full first, then light[4], then light[3].
  - light[2:0] remains 0 throughout.
- Held request: keep right=1 for 500 cycles → three sequences run, each separated by exactly one IDLE cycle with active=0.
- Hazard, macro on: left=right=1 → all six bits show duty 3/256, then 15, then 63, then constant on. IDLE is reached after 64 cycles.
- Hazard, macro off: left=right=1 → light=0 and active=0 indefinitely.
- Reset mid-sequence: assert reset at cycle 100 of a right sequence → light=0 in the same cycle and pcnt=0.
